// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled serial receiver (8N1) with sticky frame/overrun flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity check and a parity_err flag.
module uart_receiver #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       err_clr,
    output logic       busy
);

    // state     | meaning
    // IDLE      | line idle, waiting for a synchronized falling edge
    // START     | confirming the start bit at its mid-point
    // DATA      | shifting in 8 data bits, LSB first
    // PARITY    | checking even parity (UART_RX_PARITY_EN only)
    // STOP      | sampling the stop bit, delivering the byte
    // WAIT_HIGH | stop bit was low; waiting for the line to return high
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t        state, state_nxt;
    logic          rx_s1, rx_s2, rx_prev;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick, sample, fall;
    logic          load_byte, set_ferr, set_ovr, shift_en;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, set_perr;
`endif

    assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
    // os_cnt wraps every 16 ticks, so mid-bit is always the 8th tick of a bit
    assign sample  = tick && (os_cnt == 4'd7);
    assign fall    = rx_prev && !rx_s2;
    assign set_ovr = load_byte && rx_valid && !rx_ack;

    always_ff @(posedge sys_clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_byte = 1'b0;
        set_ferr  = 1'b0;
        shift_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
        set_perr  = 1'b0;
`endif
        busy      = (state != IDLE);
        case (state)
            IDLE:      if (fall) state_nxt = START;
            START:     if (sample) state_nxt = rx_s2 ? IDLE : DATA;
            DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
                    if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    set_perr  = (^shreg) ^ rx_s2;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    if (rx_s2) begin
`ifdef UART_RX_PARITY_EN
                        load_byte = !par_bad;
`else
                        load_byte = 1'b1;
`endif
                        state_nxt = IDLE;
                    end else begin
                        set_ferr  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: if (rx_s2) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            tick_cnt  <= '0;
            os_cnt    <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_s1   <= UART_RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;

            // held at zero while idle so every frame starts its tick phase at the edge
            if (state == IDLE) begin
                tick_cnt <= '0;
                os_cnt   <= 4'd0;
            end else if (tick) begin
                tick_cnt <= '0;
                os_cnt   <= os_cnt + 4'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (state != DATA) bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

            if (shift_en) shreg <= {rx_s2, shreg[7:1]};

            if (load_byte) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (set_ferr)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;

            if (set_ovr)      overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == START) par_bad <= 1'b0;
            else if (set_perr)  par_bad <= 1'b1;

            if (set_perr)     parity_err <= 1'b1;
            else if (err_clr) parity_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a cycle-scheduled behavioural model of the receiver.
// Expected outputs come from frame timing arithmetic; literal checks pin the model.
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int CLK_FREQ = 6_500_000;
    localparam int BAUD     = 100_000;
    localparam int TD       = CLK_FREQ / (BAUD * 16);   // 4 clocks per oversample tick
    localparam int BITC     = 16 * TD;                  // clocks per bit
    localparam int NSTOP    = 9 + PB;                   // index of the stop bit in the frame
    localparam int LAT_LIT  = (PB == 1) ? 674 : 610;    // hand-computed edge of rx_valid rise
    localparam int NEVER    = 32'h7fff_ffff;

    logic       sys_clk = 1'b0;
    logic       reset, UART_RX, rx_ack, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         cyc;
        int         kind;   // 0 good byte, 1 frame error, 2 parity error
        logic [7:0] d;
    } ev_t;

    ev_t        ev_q[$];
    int         vectors = 0, miscompares = 0;
    int         cyc = 0, bstart = 0, bend = 0, last_rise = -1;
    logic       valid_q = 1'b0;
    logic [7:0] exp_data;
    logic       exp_valid, exp_ferr, exp_ovr, exp_perr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void push_ev(input int c, input int k, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.d    = d;
        ev_q.push_back(e);
    endfunction

    // Model: applies scheduled frame outcomes and the consumer strobes at each edge.
    always @(posedge sys_clk) begin : model
        ev_t        e;
        bit         good, fe, pe, ov;
        logic [7:0] nd;
        cyc++;
        good = 0; fe = 0; pe = 0; nd = 8'h00;
        if (!reset) begin
            exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0;
            exp_ovr = 1'b0; exp_perr = 1'b0;
            ev_q.delete();
            bend = cyc;
        end else begin
            while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                e = ev_q.pop_front();
                if (e.cyc == cyc) begin
                    if (e.kind == 0) begin good = 1; nd = e.d; end
                    else if (e.kind == 1) fe = 1;
                    else pe = 1;
                end
            end
            ov = good && exp_valid && !rx_ack;
            if (good) begin exp_data = nd; exp_valid = 1'b1; end
            else if (rx_ack) exp_valid = 1'b0;
            exp_ferr = fe ? 1'b1 : (err_clr ? 1'b0 : exp_ferr);
            exp_ovr  = ov ? 1'b1 : (err_clr ? 1'b0 : exp_ovr);
            exp_perr = pe ? 1'b1 : (err_clr ? 1'b0 : exp_perr);
        end
    end

    always begin : compare
        @(posedge sys_clk);
        #1;
        check("rx_data", rx_data, exp_data);
        check("rx_valid", rx_valid, exp_valid);
        check("frame_err", frame_err, exp_ferr);
        check("overrun", overrun, exp_ovr);
`ifdef UART_RX_PARITY_EN
        check("parity_err", parity_err, exp_perr);
`endif
        check("busy", busy, (cyc >= bstart && cyc < bend));
        if (rx_valid && !valid_q) last_rise = cyc;
        valid_q = rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse(input bit clr);
        @(negedge sys_clk);
        if (clr) err_clr = 1'b1; else rx_ack = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        rx_ack  = 1'b0;
    endtask

    // Drives one whole frame; optionally strobes rx_ack / err_clr on the completion edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit par_ok,
                              input bit ack_hit, input bit clr_hit, output int c0);
        logic [10:0] fr;
        int          ev;
        bit          ok;
        ok = par_ok || (PB == 0);
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (PB == 1) fr[9] = par_ok ? ^d : ~(^d);
        fr[NSTOP] = stop;
        @(negedge sys_clk);
        c0 = cyc + 1;
        ev = c0 + 2 + (8 + 16 * NSTOP) * TD;
        if (!ok) push_ev(c0 + 2 + (8 + 16 * 9) * TD, 2, d);
        if (!stop) push_ev(ev, 1, d);
        else if (ok) push_ev(ev, 0, d);
        bstart = c0 + 2;
        bend   = stop ? ev : NEVER;
        for (int k = 0; k < (NSTOP + 1) * BITC; k++) begin
            UART_RX = fr[k / BITC];
            rx_ack  = ack_hit && (c0 + k == ev);
            err_clr = clr_hit && (c0 + k == ev);
            @(negedge sys_clk);
        end
        UART_RX = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        if (!stop) bend = c0 + (NSTOP + 1) * BITC + 2;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin : stim
        int c0;
        reset = 1'b0; UART_RX = 1'b1; rx_ack = 1'b0; err_clr = 1'b0;
        idle(5);
        reset = 1'b1;
        idle(20);
        check("lit_rst_data", rx_data, 8'h00);
        check("lit_rst_busy", busy, 1'b0);

        send_frame(8'h55, 1'b1, 1, 0, 0, c0);
        check("lit_55_data", rx_data, 8'h55);
        check("lit_55_valid", rx_valid, 1'b1);
        check("lit_55_latency", last_rise - c0, LAT_LIT);
        check("lit_55_ferr", frame_err, 1'b0);
        check("lit_55_ovr", overrun, 1'b0);
        pulse(0);
        idle(10);

        send_frame(8'hA3, 1'b0, 1, 0, 0, c0);
        idle(BITC);
        check("lit_a3_ferr", frame_err, 1'b1);
        check("lit_a3_valid", rx_valid, 1'b0);
        check("lit_a3_data", rx_data, 8'h55);
        send_frame(8'h3C, 1'b1, 1, 0, 0, c0);
        check("lit_3c_data", rx_data, 8'h3C);
        pulse(0);
        pulse(1);
        check("lit_ferr_clr", frame_err, 1'b0);

        send_frame(8'h12, 1'b1, 1, 0, 0, c0);
        send_frame(8'h34, 1'b1, 1, 0, 0, c0);
        check("lit_ovr_set", overrun, 1'b1);
        check("lit_ovr_data", rx_data, 8'h34);
        pulse(1);
        check("lit_ovr_clr", overrun, 1'b0);
        pulse(0);
        idle(10);

        // short low glitch on an idle line
        @(negedge sys_clk);
        c0 = cyc + 1;
        bstart = c0 + 2;
        bend   = c0 + 2 + 8 * TD;
        UART_RX = 1'b0;
        idle(12);
        UART_RX = 1'b1;
        idle(BITC);
        check("lit_glitch_busy", busy, 1'b0);
        check("lit_glitch_valid", rx_valid, 1'b0);
        check("lit_glitch_ferr", frame_err, 1'b0);

        send_frame(8'hC5, 1'b1, 1, 0, 0, c0);
        send_frame(8'h6A, 1'b1, 1, 1, 0, c0);
        check("lit_ackhit_data", rx_data, 8'h6A);
        check("lit_ackhit_valid", rx_valid, 1'b1);
        check("lit_ackhit_ovr", overrun, 1'b0);

        // reset in the middle of data bit 4 of 0xFF
        @(negedge sys_clk);
        c0 = cyc + 1;
        bstart = c0 + 2;
        bend   = NEVER;
        UART_RX = 1'b0;
        idle(BITC);
        UART_RX = 1'b1;
        idle(4 * BITC + BITC / 2);
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(5 * BITC);
        check("lit_mrst_data", rx_data, 8'h00);
        check("lit_mrst_valid", rx_valid, 1'b0);
        check("lit_mrst_busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1, 0, 0, c0);
        check("lit_81_data", rx_data, 8'h81);
        pulse(0);

        send_frame(8'hA3, 1'b0, 1, 0, 1, c0);
        idle(BITC);
        check("lit_clrhit_ferr", frame_err, 1'b1);
        pulse(1);
        check("lit_clrhit_after", frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 0, 0, 0, c0);
        idle(4);
        check("lit_par_bad_perr", parity_err, 1'b1);
        check("lit_par_bad_valid", rx_valid, 1'b0);
        send_frame(8'h07, 1'b1, 1, 0, 0, c0);
        check("lit_par_ok_data", rx_data, 8'h07);
        check("lit_par_ok_valid", rx_valid, 1'b1);
`endif
        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port UART_RX  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last correctly received byte.
REQ-007 SHALL have port rx_valid  output  1  byte available in rx_data; held until acknowledged.
REQ-008 SHALL have port rx_ack  input  1  consumer read strobe; clears rx_valid.
REQ-009 SHALL have port frame_err  output  1  sticky; stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky; byte completed while rx_valid was already high.
REQ-011 SHALL have port err_clr  input  1  clears frame_err, overrun and parity_err.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass UART_RX through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-014 SHALL generate a 16x oversample tick every TICK_DIV = CLK_FREQ/(BAUD*16) cycles, integer division (651 at defaults); the tick counter restarts at 0 on each start-bit edge.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY (macro only), STOP and WAIT_HIGH.
REQ-016 IDLE -> START on a synchronized 1->0 transition.
REQ-017 START: at tick 8 the line is sampled; if low -> DATA, if high -> IDLE as a glitch, with no flag and no output change.
REQ-018 DATA: 8 bits are sampled every 16 ticks at mid-bit, LSB first, into a shift register.
REQ-019 STOP: the line is sampled at mid-bit. If high: rx_data is loaded and rx_valid is set on the next cycle, then -> IDLE. If low: frame_err is set, rx_data and rx_valid are unchanged, then -> WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE once the synchronized line is high; a new start bit is not detected until then.
REQ-021 Latency: rx_valid SHALL rise exactly 1 cycle after the stop-bit mid-sample.
REQ-022 rx_ack clears rx_valid on the next edge. If rx_ack and a new byte completion coincide, rx_valid stays high, the new byte is loaded and overrun is not set.
REQ-023 A completion while rx_valid=1 and rx_ack=0 sets overrun and overwrites rx_data with the newer byte.
REQ-024 err_clr clears the sticky flags. An error event in the same cycle as err_clr wins and leaves its flag set.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL go to IDLE and clear the tick counter, bit counter and shift register.
REQ-026 Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
REQ-027 Reset mid-frame SHALL abandon the frame without a partial update; after release, reception restarts only on a fresh 1->0 edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: state PARITY sits between DATA and STOP, even parity is checked, and an output port parity_err (1 bit, sticky) is present. A mismatch sets parity_err, the byte is discarded (rx_valid and rx_data unchanged), and the stop bit is still checked.
REQ-029 Macro UART_RX_PARITY_EN undefined: the frame is 8N1, with no PARITY state and no parity_err port.

Verification
REQ-030 Bit period is 104160 ns at the defaults. Send 0x55 as 8N1 -> rx_data=8'h55, rx_valid=1 one cycle after the stop mid-sample; frame_err=0 and overrun=0.
REQ-031 Send 0xA3 and hold the stop bit at 0 -> frame_err=1, rx_valid=0, rx_data unchanged. The line must return high before the next byte, 0x3C, is received correctly.
REQ-032 Send 0x12, then 0x34 with no rx_ack -> overrun=1, rx_data=8'h34. Then pulse err_clr -> overrun=0.
REQ-033 Apply a 2000 ns low glitch on an idle line -> state returns to IDLE, no flags, rx_valid=0.
REQ-034 Assert reset low during data bit 4 of 0xFF -> all outputs at reset values. A following 0x81 is received correctly.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err=1, rx_valid=0. With parity bit 1 -> rx_data=8'h07, rx_valid=1.
